// File: rtl/servo_cmd_decoder.sv
// Serial byte-command decoder driving a servo PWM compare value.
// Parses '+', '-', 'c', '?', 'p'<hi><lo> commands and slews compare toward the target.
module servo_cmd_decoder #(
  parameter int POS_W       = 10,
  parameter int MIN_POS     = 51,
  parameter int MAX_POS     = 102,
  parameter int CENTER      = 77,
  parameter int STEP        = 5,
  parameter int SLEW_DIV    = 50000,
  parameter int ARG_TIMEOUT = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  input  logic             tx_busy,
  output logic [POS_W-1:0] compare,
  output logic             at_target,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, ARG_HI, ARG_LO, TX_A, TX_B} state_t;

  localparam int SLEW_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int TO_W   = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;

  localparam logic [POS_W-1:0]  MIN_P     = POS_W'(MIN_POS);
  localparam logic [POS_W-1:0]  MAX_P     = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]  CTR_P     = POS_W'(CENTER);
  localparam logic [POS_W-1:0]  STEP_P    = POS_W'(STEP);
  localparam logic [POS_W:0]    STEP_X    = (POS_W+1)'(STEP);
  localparam logic [SLEW_W-1:0] SLEW_LAST = SLEW_W'(SLEW_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ARG_TIMEOUT - 1);
  localparam logic [7:0]        ACK       = 8'h6B;
  localparam logic [7:0]        NAK       = 8'h21;

  state_t            state;
  logic [POS_W-1:0]  target;
  logic [7:0]        arg_hi;
  logic [7:0]        tx_lo;
  logic              two_byte;
  logic [SLEW_W-1:0] slew_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic [POS_W:0]    inc_sum;
  logic [POS_W-1:0]  plus_pos;
  logic [POS_W-1:0]  minus_pos;
  logic [POS_W-1:0]  arg_pos;
  logic [15:0]       arg_raw;
  logic [15:0]       cmp16;

  // Saturating arithmetic for the next target; '-' compares before subtracting
  // so an unsigned target can never wrap below zero.
  always_comb begin
    inc_sum   = {1'b0, target} + STEP_X;
    plus_pos  = (inc_sum > {1'b0, MAX_P}) ? MAX_P : inc_sum[POS_W-1:0];
    minus_pos = (target >= MIN_P + STEP_P) ? target - STEP_P : MIN_P;
    arg_raw   = {arg_hi, rx_data};
    if (arg_raw < 16'(MIN_POS))      arg_pos = MIN_P;
    else if (arg_raw > 16'(MAX_POS)) arg_pos = MAX_P;
    else                             arg_pos = POS_W'(arg_raw);
    cmp16     = 16'(compare);
  end

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; blocking ones would let later statements see half-updated values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      target      <= CTR_P;
      compare     <= CTR_P;
      tx_data     <= 8'h00;
      new_tx_data <= 1'b0;
      at_target   <= 1'b1;
      overrun     <= 1'b0;
      arg_hi      <= 8'h00;
      tx_lo       <= 8'h00;
      two_byte    <= 1'b0;
      slew_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      new_tx_data <= 1'b0;
      at_target   <= (compare == target);

      if (slew_cnt == SLEW_LAST) begin
        slew_cnt <= '0;
        if (compare < target)      compare <= compare + POS_W'(1);
        else if (compare > target) compare <= compare - POS_W'(1);
      end else begin
        slew_cnt <= slew_cnt + SLEW_W'(1);
      end

      case (state)
        IDLE: begin
          if (new_rx_data) begin
            // Replies are launched straight away when the transmitter is free.
            state       <= TX_A;
            new_tx_data <= !tx_busy;
            tx_data     <= ACK;
            two_byte    <= 1'b0;
            case (rx_data)
              8'h2B: target <= plus_pos;
              8'h2D: target <= minus_pos;
              8'h63: target <= CTR_P;
              8'h70: begin
                state       <= ARG_HI;
                new_tx_data <= 1'b0;
                to_cnt      <= '0;
              end
              8'h3F: begin
                tx_data  <= cmp16[15:8];
                tx_lo    <= cmp16[7:0];
                two_byte <= 1'b1;
              end
              default: tx_data <= NAK;
            endcase
          end
        end

        ARG_HI, ARG_LO: begin
          if (new_rx_data) begin
            to_cnt <= '0;
            if (state == ARG_HI) begin
              arg_hi <= rx_data;
              state  <= ARG_LO;
            end else begin
              target      <= arg_pos;
              tx_data     <= ACK;
              two_byte    <= 1'b0;
              new_tx_data <= !tx_busy;
              state       <= TX_A;
            end
          end else if (to_cnt == TO_LAST) begin
            tx_data     <= NAK;
            two_byte    <= 1'b0;
            new_tx_data <= !tx_busy;
            state       <= TX_A;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        TX_A, TX_B: begin
          if (new_rx_data) overrun <= 1'b1;
          // A visible pulse means this byte has been handed over; move on and
          // leave one idle cycle so tx_busy can rise before the next byte.
          if (new_tx_data) begin
            if (state == TX_A && two_byte) begin
              state   <= TX_B;
              tx_data <= tx_lo;
            end else begin
              state <= IDLE;
            end
          end else begin
            new_tx_data <= !tx_busy;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
